// File: rtl/operaters_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : operaters_arbiter
//  Purpose  : Shares one DW-bit operator datapath (add/sub/logic/shift)
//             between two requesters. Arbitration is round-robin, requests
//             use valid/ready handshakes, and a single result register
//             supports backpressure. op_cnt counts consumed results (wraps).
//  Ports    : clk, rst            - clock, asynchronous active-high reset
//             reqN_vld/rdy        - request handshake, N = 0,1
//             reqN_op/a/b         - opcode and operands of requester N
//             res_vld/rdy         - result handshake
//             res_id/data/flag    - owner, value, carry/borrow of result
//             op_cnt              - 8-bit completed-operation counter
//  Revision : 1.0 - initial release
// ============================================================================
module operaters_arbiter #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_vld,
    output logic          req0_rdy,
    input  logic [2:0]    req0_op,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic          req1_vld,
    output logic          req1_rdy,
    input  logic [2:0]    req1_op,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    output logic          res_vld,
    input  logic          res_rdy,
    output logic          res_id,
    output logic [DW-1:0] res_data,
    output logic          res_flag,
    output logic [7:0]    op_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_last;      // requester that owned the last consumed result
    logic [2:0]    r_op;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic          r_id;
    logic          r_res_vld;
    logic          r_res_id;
    logic [DW-1:0] r_res_data;
    logic          r_res_flag;
    logic [7:0]    r_op_cnt;

    logic          w_grant0;
    logic          w_grant1;
    logic          w_idle;
    logic [DW:0]   w_result;    // MSB carries carry/borrow for add/sub

    // Under contention the requester that did not own the last result wins.
    // r_last resets to 1 so requester 0 wins the first contention.
    assign w_grant0 = req0_vld && (!req1_vld ||  r_last);
    assign w_grant1 = req1_vld && (!req0_vld || !r_last);
    assign w_idle   = (r_state == ST_IDLE);

    assign req0_rdy = w_idle && w_grant0 && !rst;
    assign req1_rdy = w_idle && w_grant1 && !rst;

    assign res_vld  = r_res_vld;
    assign res_id   = r_res_id;
    assign res_data = r_res_data;
    assign res_flag = r_res_flag;
    assign op_cnt   = r_op_cnt;

    always_comb begin
        w_result = '0;
        case (r_op)
            3'b000:  w_result = {1'b0, r_a} + {1'b0, r_b};
            3'b001:  w_result = {1'b0, r_a} - {1'b0, r_b};  // MSB set on borrow
            3'b010:  w_result = {1'b0, r_a & r_b};
            3'b011:  w_result = {1'b0, r_a | r_b};
            3'b100:  w_result = {1'b0, r_a ^ r_b};
            3'b101:  w_result = {1'b0, ~r_a};
            3'b110:  w_result = {1'b0, r_a << r_b[2:0]};
            default: w_result = {1'b0, r_a >> r_b[2:0]};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_last     <= 1'b1;
            r_op       <= 3'b000;
            r_a        <= '0;
            r_b        <= '0;
            r_id       <= 1'b0;
            r_res_vld  <= 1'b0;
            r_res_id   <= 1'b0;
            r_res_data <= '0;
            r_res_flag <= 1'b0;
            r_op_cnt   <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Grants are mutually exclusive, so the handshake is
                    // simply whichever grant is active.
                    if (w_grant0) begin
                        r_op    <= req0_op;
                        r_a     <= req0_a;
                        r_b     <= req0_b;
                        r_id    <= 1'b0;
                        r_state <= ST_EXEC;
                    end else if (w_grant1) begin
                        r_op    <= req1_op;
                        r_a     <= req1_a;
                        r_b     <= req1_b;
                        r_id    <= 1'b1;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_res_data <= w_result[DW-1:0];
                    // Only add and sub report a flag.
                    r_res_flag <= (r_op == 3'b000 || r_op == 3'b001) ? w_result[DW] : 1'b0;
                    r_res_id   <= r_id;
                    r_res_vld  <= 1'b1;
                    r_state    <= ST_DONE;
                end
                ST_DONE: begin
                    // Result fields stay put after consumption; only the
                    // valid flag drops.
                    if (res_rdy) begin
                        r_res_vld <= 1'b0;
                        r_last    <= r_res_id;
                        r_op_cnt  <= r_op_cnt + 8'd1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_operaters_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operaters_arbiter
//  Purpose  : Self-checking bench for operaters_arbiter. Stimulus pushes the
//             hand-computed result {id, flag, data} into a scoreboard queue;
//             a monitor pops and compares on every result consumption and
//             tracks op_cnt, hold stability and request-ready exclusion.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_operaters_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_vld, req1_vld;
    logic       req0_rdy, req1_rdy;
    logic [2:0] req0_op,  req1_op;
    logic [7:0] req0_a,   req1_a;
    logic [7:0] req0_b,   req1_b;
    logic       res_vld;
    logic       res_rdy;
    logic       res_id;
    logic [7:0] res_data;
    logic       res_flag;
    logic [7:0] op_cnt;

    int checks   = 0;
    int failures = 0;

    logic [9:0] sb[$];          // {id, flag, data}
    logic [7:0] exp_cnt = 8'd0;
    logic       hold    = 1'b0;
    logic [9:0] hold_val = '0;

    operaters_arbiter #(.DW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0_vld (req0_vld),
        .req0_rdy (req0_rdy),
        .req0_op  (req0_op),
        .req0_a   (req0_a),
        .req0_b   (req0_b),
        .req1_vld (req1_vld),
        .req1_rdy (req1_rdy),
        .req1_op  (req1_op),
        .req1_a   (req1_a),
        .req1_b   (req1_b),
        .res_vld  (res_vld),
        .res_rdy  (res_rdy),
        .res_id   (res_id),
        .res_data (res_data),
        .res_flag (res_flag),
        .op_cnt   (op_cnt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drives a request and waits (bounded) for its handshake; returns at the
    // negedge after the accepting posedge with vld dropped.
    task automatic send(input int n, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, output int waited);
        logic r;
        waited = 0;
        if (n == 0) begin req0_op = op; req0_a = a; req0_b = b; req0_vld = 1'b1; end
        else        begin req1_op = op; req1_a = a; req1_b = b; req1_vld = 1'b1; end
        #1;
        r = (n == 0) ? req0_rdy : req1_rdy;
        while (!r) begin
            if (waited >= 40) begin
                checks++;
                failures++;
                $display("FAIL handshake_timeout req%0d actual=no_rdy required=rdy", n);
                if (n == 0) req0_vld = 1'b0; else req1_vld = 1'b0;
                return;
            end
            @(negedge clk); #1;
            waited++;
            r = (n == 0) ? req0_rdy : req1_rdy;
        end
        @(negedge clk);
        if (n == 0) req0_vld = 1'b0; else req1_vld = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #3;
            if (sb.size() == 0 && !res_vld) return;
        end
        checks++;
        failures++;
        $display("FAIL drain_timeout actual=%0d_pending required=0", sb.size());
    endtask

    // Monitor: samples 2 time units after each negedge, once stimulus settled.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            exp_cnt = 8'd0;
            sb.delete();
            hold = 1'b0;
        end else begin
            chk("op_cnt", {24'd0, op_cnt}, {24'd0, exp_cnt});
            if (hold) begin
                chk("hold_vld", {31'd0, res_vld}, 32'd1);
                chk("hold_result", {22'd0, res_id, res_flag, res_data}, {22'd0, hold_val});
            end
            if (res_vld)
                chk("rdy_while_busy", {30'd0, req0_rdy, req1_rdy}, 32'd0);
            if (res_vld && res_rdy) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual=%0h required=none",
                             {res_id, res_flag, res_data});
                end else begin
                    chk("result", {22'd0, res_id, res_flag, res_data}, {22'd0, sb.pop_front()});
                end
                exp_cnt = exp_cnt + 8'd1;
            end
            hold     = res_vld && !res_rdy;
            hold_val = {res_id, res_flag, res_data};
        end
    end

    initial begin
        int w0, w1;
        rst = 1'b1;
        req0_vld = 1'b1; req0_op = 3'd0; req0_a = 8'd0; req0_b = 8'd0;
        req1_vld = 1'b0; req1_op = 3'd0; req1_a = 8'd0; req1_b = 8'd0;
        res_rdy = 1'b0;

        // Reset state; req0_vld high must still give rdy 0.
        #50;
        chk("rst_res_vld",  {31'd0, res_vld},  32'd0);
        chk("rst_res_id",   {31'd0, res_id},   32'd0);
        chk("rst_res_data", {24'd0, res_data}, 32'd0);
        chk("rst_res_flag", {31'd0, res_flag}, 32'd0);
        chk("rst_op_cnt",   {24'd0, op_cnt},   32'd0);
        chk("rst_rdy",      {30'd0, req0_rdy, req1_rdy}, 32'd0);
        req0_vld = 1'b0;
        #50;                    // t=100, a negedge
        rst = 1'b0;

        // Idle with no requests.
        repeat (3) @(negedge clk);
        #1;
        chk("idle_rdy", {30'd0, req0_rdy, req1_rdy}, 32'd0);
        chk("idle_res_vld", {31'd0, res_vld}, 32'd0);

        // Single add: F0 + 20 = 110 -> data 10, carry 1.
        res_rdy = 1'b1;
        @(negedge clk);
        sb.push_back({1'b0, 1'b1, 8'h10});
        send(0, 3'b000, 8'hF0, 8'h20, w0);
        chk("add_first_cycle_grant", w0, 32'd0);
        #1;
        chk("add_exec_no_vld", {31'd0, res_vld}, 32'd0);
        @(negedge clk); #1;
        chk("add_res_vld", {31'd0, res_vld}, 32'd1);
        wait_drain();

        // Shifts / not from requester 1 (also leaves last=1).
        sb.push_back({1'b1, 1'b0, 8'h08});
        send(1, 3'b110, 8'h81, 8'h0B, w1);
        sb.push_back({1'b1, 1'b0, 8'h10});
        send(1, 3'b111, 8'h81, 8'h03, w1);
        sb.push_back({1'b1, 1'b0, 8'hF0});
        send(1, 3'b101, 8'h0F, 8'h00, w1);
        wait_drain();

        // Contention: both continuously valid, order 0,1,0,1.
        sb.push_back({1'b0, 1'b1, 8'hFE});
        sb.push_back({1'b1, 1'b0, 8'h55});
        sb.push_back({1'b0, 1'b1, 8'hFE});
        sb.push_back({1'b1, 1'b0, 8'h55});
        fork
            begin
                int wa;
                send(0, 3'b001, 8'h05, 8'h07, wa);
                send(0, 3'b001, 8'h05, 8'h07, wa);
            end
            begin
                int wb;
                send(1, 3'b100, 8'hAA, 8'hFF, wb);
                send(1, 3'b100, 8'hAA, 8'hFF, wb);
            end
        join
        wait_drain();

        // Backpressure: result held, req1 pending but never granted.
        res_rdy = 1'b0;
        sb.push_back({1'b0, 1'b0, 8'h3C});
        send(0, 3'b011, 8'h0C, 8'h30, w0);
        req1_op = 3'b010; req1_a = 8'hF0; req1_b = 8'h3C; req1_vld = 1'b1;
        sb.push_back({1'b1, 1'b0, 8'h30});
        repeat (6) begin
            @(negedge clk); #1;
            chk("bp_req1_rdy", {31'd0, req1_rdy}, 32'd0);
        end
        chk("bp_res_vld", {31'd0, res_vld}, 32'd1);
        res_rdy = 1'b1;
        send(1, 3'b010, 8'hF0, 8'h3C, w1);
        wait_drain();

        // Reset while a result is pending in DONE.
        res_rdy = 1'b0;
        send(1, 3'b000, 8'h01, 8'h02, w1);
        @(negedge clk); #1;
        chk("pre_rst_res_vld", {31'd0, res_vld}, 32'd1);
        chk("pre_rst_op_cnt", {24'd0, op_cnt}, 32'd10);
        #4;
        rst = 1'b1;
        #1;
        chk("async_rst_res_vld", {31'd0, res_vld}, 32'd0);
        chk("async_rst_op_cnt",  {24'd0, op_cnt},  32'd0);
        chk("async_rst_res_data", {24'd0, res_data}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        res_rdy = 1'b1;
        sb.push_back({1'b0, 1'b0, 8'h30});
        sb.push_back({1'b1, 1'b0, 8'h03});
        fork
            begin
                int wa;
                send(0, 3'b010, 8'hF0, 8'h3C, wa);
            end
            begin
                int wb;
                send(1, 3'b011, 8'h01, 8'h02, wb);
            end
        join
        wait_drain();
        @(negedge clk); #3;
        chk("final_op_cnt", {24'd0, op_cnt}, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/operaters_arbiter.md
Name: operaters_arbiter

Overview:
- Shares one 8-bit operator datapath (add/sub/logic/shift) between two requesters.
- Round-robin arbitration, valid/ready request handshakes, single result register with backpressure.
- Sits in front of the operator demo datapath. `op_cnt` gives a free-running completed-operation count, the same kind of 8-bit observable output the existing operator blocks expose.

Parameters:
- DW, 8, operand/result width; op_cnt stays 8 bits regardless.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req0_vld  in  1  requester 0 has an operation pending
- req0_rdy  out  1  requester 0 accepted this cycle when req0_vld&&req0_rdy
- req0_op  in  3  requester 0 opcode
- req0_a  in  DW  requester 0 operand A
- req0_b  in  DW  requester 0 operand B
- req1_vld, req1_rdy, req1_op, req1_a, req1_b: same as requester 0, for requester 1
- res_vld  out  1  result valid
- res_rdy  in  1  consumer takes result when res_vld&&res_rdy
- res_id  out  1  requester index that owns res_data
- res_data  out  DW  operation result
- res_flag  out  1  carry (add) / borrow (sub), else 0
- op_cnt  out  8  number of completed (consumed) results, wraps

Behaviour:
- Reset (async, immediate):
  - state=IDLE, res_vld=0, res_id=0, res_data=0, res_flag=0, op_cnt=0.
  - req0_rdy=req1_rdy=0 while rst high.
  - Round-robin pointer last=1, so requester 0 wins the first contention.
- FSM IDLE -> EXEC -> DONE -> IDLE. One operation in flight; minimum 3 cycles per operation.
- IDLE:
  - grant is combinational from vld and last.
  - Only one vld high -> that requester is granted.
  - Both high -> grant the requester != last.
  - reqN_rdy = (state==IDLE) && grantN && !rst; never both high.
  - On the handshake, register op/a/b/id and go to EXEC. No vld -> stay in IDLE.
- EXEC (1 cycle):
  - Compute from the registered operands; load res_data/res_flag/res_id; set res_vld=1.
  - Go to DONE. Both rdy are 0.
- Opcodes (res_flag=0 unless stated):
  - 000: a+b, flag=carry out of bit DW-1.
  - 001: a-b mod 2^DW, flag=1 iff a<b unsigned.
  - 010: a&b.
  - 011: a|b.
  - 100: a^b.
  - 101: ~a.
  - 110: a<<b[2:0], zero-fill.
  - 111: a>>b[2:0], logical.
- DONE:
  - res_* held stable while res_vld && !res_rdy (any number of cycles).
  - On res_rdy: res_vld->0 next edge; last<=res_id; op_cnt<=op_cnt+1 (255->0); go to IDLE.
  - res_data/res_id/res_flag keep their last values after res_vld drops.
- Requester rules:
  - A requester keeps vld/op/a/b stable until its handshake.
  - Inputs changing while rdy=0 are ignored.
  - A requester may present back-to-back operations; after its result is consumed it loses priority to the other requester if both are valid.
- Simultaneous events:
  - A requester asserting vld in DONE is not served until the cycle after consumption, when the FSM is back in IDLE.
  - res_rdy high outside DONE has no effect.
- Reset mid-operation: the captured operation and any pending result are discarded. No op_cnt increment. Neither requester sees a handshake for the lost operation.

Test Plan:
- Reset release: rst high 100 ns, clk period 20 ns → all outputs 0, rdy 0 during reset. After release, with no vld, the FSM stays IDLE and op_cnt=0.
- Single add: req0 op=000 a=8'hF0 b=8'h20, res_rdy=1 → req0_rdy high the first IDLE cycle. Two edges later res_vld=1, res_data=8'h10, res_flag=1, res_id=0; op_cnt=1 after consumption.
- Contention round-robin: both vld continuously, req0 op=001 a=5 b=7; req1 op=100 a=8'hAA b=8'hFF → grant order 0,1,0,1. Results 8'hFE flag=1 (id0) and 8'h55 flag=0 (id1); op_cnt=4 after four results.
- Backpressure: res_rdy=0 for 5 cycles after res_vld → res_data/res_id stable, both rdy 0, no new grant. res_rdy=1 → one consumption, op_cnt increments once.
- Shifts/not: op=110 a=8'h81 b=8'h0B → 8'h08; op=111 a=8'h81 b=3 → 8'h10; op=101 a=8'h0F → 8'hF0, flag 0 for all three.
- Reset in DONE with res_vld=1 and op_cnt=3: assert rst → res_vld=0 and op_cnt=0 immediately (asynchronous). After release with both vld high, req0 is granted first.
